// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a UART transmitter, with message
// locking, lock-idle release and a start-timeout fault.
module uart_tx_arbiter #(
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd65535,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_transmitting,
  output logic       owner,
  output logic       locked,
  output logic       lock_timeout,
  output logic       tx_fault
);

  // state      | meaning
  // IDLE       | arbitrating; grants only while the UART is not busy
  // ISSUE      | one-cycle transmit pulse for the latched byte
  // WAIT_START | waiting for UART busy to rise, bounded by START_TIMEOUT
  // WAIT_DONE  | waiting for UART busy to fall
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  localparam int          SCW       = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [SCW-1:0] START_LAST = SCW'(START_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST = LOCK_TIMEOUT - 16'd1;

  state_t           state_q, state_d;
  logic [7:0]       tx_byte_q;
  logic             owner_q, locked_q;
  logic [15:0]      lock_cnt_q;
  logic [SCW-1:0]   start_cnt_q;

  logic own_valid, elig0, elig1, grant, can_grant, accept;
  logic lock_idle, lock_expire, start_expire;

  always_comb begin
    state_d      = state_q;
    own_valid    = owner_q ? req1_valid : req0_valid;
    elig0        = req0_valid && (!locked_q || !owner_q);
    elig1        = req1_valid && (!locked_q || owner_q);
    can_grant    = !rst && (state_q == IDLE) && !uart_is_transmitting;
    // on a tie the requester that did not hold the last grant wins
    grant        = (elig0 && elig1) ? !owner_q : elig1;
    req0_ready   = can_grant && elig0 && !grant;
    req1_ready   = can_grant && elig1 && grant;
    accept       = req0_ready || req1_ready;
    lock_idle    = !rst && (state_q == IDLE) && locked_q && !own_valid;
    lock_expire  = lock_idle && (lock_cnt_q == LOCK_LAST);
    start_expire = !rst && (state_q == WAIT_START) && !uart_is_transmitting &&
                   (start_cnt_q == START_LAST);
    case (state_q)
      IDLE:       if (accept) state_d = ISSUE;
      ISSUE:      state_d = WAIT_START;
      WAIT_START: begin
        if (uart_is_transmitting) state_d = WAIT_DONE;
        else if (start_expire)    state_d = IDLE;
      end
      WAIT_DONE:  if (!uart_is_transmitting) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_byte_q   <= 8'h00;
      owner_q     <= 1'b1;
      locked_q    <= 1'b0;
      lock_cnt_q  <= 16'd0;
      start_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tx_byte_q  <= req1_ready ? req1_byte : req0_byte;
        owner_q    <= req1_ready;
        locked_q   <= req1_ready ? !req1_last : !req0_last;
        lock_cnt_q <= 16'd0;
      end else if (lock_expire) begin
        locked_q   <= 1'b0;
        lock_cnt_q <= 16'd0;
      end else if (lock_idle && (lock_cnt_q != 16'hFFFF)) begin
        lock_cnt_q <= lock_cnt_q + 16'd1;
      end
      if (start_expire) locked_q <= 1'b0;
      if (state_q == ISSUE)           start_cnt_q <= '0;
      else if (state_q == WAIT_START) start_cnt_q <= start_cnt_q + SCW'(1);
    end
  end

  assign uart_transmit = !rst && (state_q == ISSUE);
  assign uart_tx_byte  = tx_byte_q;
  assign owner         = owner_q;
  assign locked        = locked_q;
  assign lock_timeout  = lock_expire;
  assign tx_fault      = start_expire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a cycle-timestamp
// reference model of the arbitration, locking and transfer rules.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int LT = 20;
  localparam int ST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
  logic [7:0] req0_byte, req1_byte, uart_tx_byte;
  logic       uart_transmit, uart_is_transmitting, owner, locked, lock_timeout, tx_fault;

  uart_tx_arbiter #(.LOCK_TIMEOUT(16'd20), .START_TIMEOUT(ST)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_byte(req0_byte), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_byte(req1_byte), .req1_last(req1_last), .req1_ready(req1_ready),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .owner(owner), .locked(locked), .lock_timeout(lock_timeout), .tx_fault(tx_fault)
  );

  int checks = 0, passed = 0, fails = 0;
  int cyc = 0;
  // UART environment: busy window [bs, be) scheduled from each transmit pulse
  int uart_delay = 1, uart_len = 10;
  bit uart_never = 0, force_busy = 0;
  int bs = -100, be = -100;
  // reference model
  bit m_known = 0, m_owner = 1, m_locked = 0, m_act = 0, m_seen = 0;
  int m_idle = 0, t_acc = 0, t_busy = 0;
  logic [7:0] m_byte = 8'h00;
  // observations
  logic [7:0] tx_log[$];
  logic [7:0] acc_log[$];
  bit acc0, acc1;
  int lt_cycle = -1, fault_cycle = -1, last_acc_cycle = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit busy, own_v, er0, er1, etx, efault, elt;
    busy = force_busy || (!uart_never && cyc >= bs && cyc < be);
    uart_is_transmitting = busy;
    #1;
    own_v = m_owner ? req1_valid : req0_valid;
    er0 = 0; er1 = 0;
    if (!rst && !m_act && !busy) begin
      if (req0_valid && req1_valid && !m_locked) begin
        er0 = m_owner; er1 = !m_owner;
      end else begin
        er0 = req0_valid && (!m_locked || !m_owner);
        er1 = req1_valid && (!m_locked || m_owner);
      end
    end
    etx    = !rst && m_act && (cyc == t_acc + 1);
    efault = !rst && m_act && !m_seen && !busy && (cyc == t_acc + 1 + ST);
    elt    = !rst && !m_act && m_locked && !own_v && (m_idle == LT - 1);
    chk("ready0", req0_ready, er0);
    chk("ready1", req1_ready, er1);
    chk("transmit", uart_transmit, etx);
    chk("tx_fault", tx_fault, efault);
    chk("lock_timeout", lock_timeout, elt);
    if (m_known) begin
      chk("owner", owner, m_owner);
      chk("locked", locked, m_locked);
      chk("tx_byte", uart_tx_byte, m_byte);
    end
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (acc0) acc_log.push_back(req0_byte);
    if (acc1) acc_log.push_back(req1_byte);
    if (acc0 || acc1) last_acc_cycle = cyc;
    if (uart_transmit) begin
      tx_log.push_back(uart_tx_byte);
      if (!uart_never) begin bs = cyc + 1 + uart_delay; be = bs + uart_len; end
    end
    if (lock_timeout) lt_cycle = cyc;
    if (tx_fault) fault_cycle = cyc;
    if (rst) begin
      m_known = 1; m_owner = 1; m_locked = 0; m_idle = 0; m_act = 0; m_byte = 8'h00;
    end else if (m_act) begin
      if (!m_seen && busy && cyc >= t_acc + 2 && cyc <= t_acc + 1 + ST) begin
        m_seen = 1; t_busy = cyc;
      end else if (efault) begin
        m_act = 0; m_locked = 0;
      end else if (m_seen && !busy && cyc > t_busy) m_act = 0;
    end else if (er0 || er1) begin
      m_act = 1; m_seen = 0; t_acc = cyc; m_owner = er1; m_idle = 0;
      m_byte   = er1 ? req1_byte : req0_byte;
      m_locked = !(er1 ? req1_last : req0_last);
    end else if (elt) begin
      m_locked = 0; m_idle = 0;
    end else if (m_locked && !own_v && m_idle < 65535) m_idle++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (m_act && n < 100) begin tick(); n++; end
    chk(tag, {31'b0, m_act}, 0);
  endtask

  initial begin
    int n;
    int ta;
    bit done;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    rst = 1; uart_is_transmitting = 0;
    req0_valid = 0; req0_byte = 0; req0_last = 0;
    req1_valid = 0; req1_byte = 0; req1_last = 0;
    @(negedge clk);
    tick();
    rst = 0;
    chk("rst_owner", owner, 1);
    chk("rst_locked", locked, 0);
    chk("rst_byte", uart_tx_byte, 8'h00);

    // round-robin between two always-valid single-byte requesters
    tx_log.delete();
    req0_valid = 1; req0_byte = 8'h41; req0_last = 1;
    req1_valid = 1; req1_byte = 8'h42; req1_last = 1;
    n = 0;
    while (tx_log.size() < 4 && n < 300) begin tick(); n++; end
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", tx_log.size(), 4);
    if (tx_log.size() >= 4) begin
      chk("rr_b0", tx_log[0], 8'h41);
      chk("rr_b1", tx_log[1], 8'h42);
      chk("rr_b2", tx_log[2], 8'h41);
      chk("rr_b3", tx_log[3], 8'h42);
    end
    wait_idle("rr_idle");

    // locked 3-byte message from req0 while req1 waits
    acc_log.delete();
    q0 = '{{1'b0, 8'h10}, {1'b0, 8'h11}, {1'b1, 8'h12}};
    req1_valid = 1; req1_byte = 8'h55; req1_last = 1;
    n = 0; done = 0;
    while (!done && n < 400) begin
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin req0_byte = q0[0][7:0]; req0_last = q0[0][8]; end
      tick(); n++;
      if (acc0) void'(q0.pop_front());
      if (acc1) done = 1;
    end
    req0_valid = 0; req1_valid = 0;
    chk("msg_count", acc_log.size(), 4);
    if (acc_log.size() >= 4) begin
      chk("msg_a0", acc_log[0], 8'h10);
      chk("msg_a1", acc_log[1], 8'h11);
      chk("msg_a2", acc_log[2], 8'h12);
      chk("msg_a3", acc_log[3], 8'h55);
    end
    wait_idle("msg_idle");

    // lock released after LT idle cycles, then the other requester wins
    req0_valid = 1; req0_byte = 8'h20; req0_last = 0;
    n = 0;
    do begin tick(); n++; end while (!acc0 && n < 50);
    req0_valid = 0;
    req1_valid = 1; req1_byte = 8'h77; req1_last = 1;
    lt_cycle = -1;
    n = 0;
    do begin tick(); n++; end while (!acc1 && n < 200);
    req1_valid = 0;
    chk("lt_cycle", lt_cycle, be + LT);
    chk("lt_grant", last_acc_cycle, lt_cycle + 1);
    wait_idle("lt_idle");

    // UART never starts: fault, unlock, immediate re-grant
    uart_never = 1;
    req0_valid = 1; req0_byte = 8'h30; req0_last = 0;
    n = 0;
    do begin tick(); n++; end while (!acc0 && n < 50);
    ta = last_acc_cycle;
    req0_valid = 0;
    fault_cycle = -1;
    n = 0;
    while (fault_cycle < 0 && n < 20) begin tick(); n++; end
    chk("fault_cycle", fault_cycle, ta + 1 + ST);
    chk("fault_unlock", locked, 0);
    uart_never = 0;
    req0_valid = 1; req0_byte = 8'h31; req0_last = 1;
    tick();
    chk("fault_regrant", acc0, 1);
    req0_valid = 0;
    wait_idle("fault_idle");

    // reset during WAIT_DONE with UART busy held high
    req1_valid = 1; req1_byte = 8'h66; req1_last = 0;
    n = 0;
    do begin tick(); n++; end while (!acc1 && n < 50);
    req1_valid = 0;
    n = 0;
    while (cyc < bs + 3 && n < 50) begin tick(); n++; end
    force_busy = 1; rst = 1;
    tick();
    rst = 0;
    chk("rst2_owner", owner, 1);
    chk("rst2_locked", locked, 0);
    chk("rst2_byte", uart_tx_byte, 8'h00);
    chk("rst2_transmit", uart_transmit, 0);
    req0_valid = 1; req0_byte = 8'h70; req0_last = 1;
    req1_valid = 1; req1_byte = 8'h71; req1_last = 1;
    n = 0;
    repeat (6) begin tick(); if (acc0 || acc1) n++; end
    chk("busy_block", n, 0);
    force_busy = 0;
    n = 0;
    do begin tick(); n++; end while (!(acc0 || acc1) && n < 40);
    chk("post_rst_grant", {acc1, acc0}, 2'b01);
    req0_valid = 0; req1_valid = 0;
    wait_idle("rst2_idle");

    // randomized messages with valid gaps and varying UART timing
    for (int m = 0; m < 10; m++) begin
      int len0 = $urandom_range(1, 3);
      int len1 = $urandom_range(1, 3);
      for (int b = 0; b < len0; b++) q0.push_back({b == len0 - 1, 8'($urandom)});
      for (int b = 0; b < len1; b++) q1.push_back({b == len1 - 1, 8'($urandom)});
    end
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 4000) begin
      uart_delay = $urandom_range(0, 2);
      uart_len   = $urandom_range(1, 4);
      req0_valid = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
      req1_valid = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      req0_byte = 8'($urandom); req0_last = 1'($urandom);
      req1_byte = 8'($urandom); req1_last = 1'($urandom);
      if (q0.size() > 0) begin req0_byte = q0[0][7:0]; req0_last = q0[0][8]; end
      if (q1.size() > 0) begin req1_byte = q1[0][7:0]; req1_last = q1[0][8]; end
      tick(); n++;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
    end
    req0_valid = 0; req1_valid = 0;
    chk("rand_drained", q0.size() + q1.size(), 0);
    wait_idle("rand_idle");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
